// File: rtl/digital_lock_ctrl.sv
// rtl/digital_lock_ctrl.sv - four-digit BCD keypad lock controller with timed open/fail/lockout states
// Optional feature: define LOCK_MASTER_CODE_EN to accept 9999 as a master code in CHECK.
module digital_lock_ctrl #(
    parameter logic [15:0] RESET_CODE     = 16'h1234,
    parameter int          OPEN_CYCLES    = 50_000_000,
    parameter int          FAIL_CYCLES    = 25_000_000,
    parameter int          LOCKOUT_CYCLES = 250_000_000,
    parameter int          MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       key0,
    input  logic       key1,
    input  logic       key2,
    input  logic       key3,
    input  logic       switch4,
    output logic [3:0] out_1,
    output logic [3:0] out_2,
    output logic [3:0] out_3,
    output logic [3:0] out_4,
    output logic       unlock,
    output logic       buzz,
    output logic [2:0] state,
    output logic [1:0] fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5,
        S_SETPW   = 3'd6
    } state_t;

    // Timer only ever counts 0 .. limit-1, so log2 of the largest limit is enough.
    localparam int MAX_A = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
    localparam int MAX_T = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LAST    = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    MAX_FAIL_L   = 2'(MAX_FAIL);

    state_t          cur_state;
    state_t          nxt_state;
    logic [2:0]      count;
    logic [15:0]     password;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_last;
    logic            timer_done;
    logic            timed_state;

    logic            k0;
    logic            k1;
    logic            k2;
    logic            k3;
    logic            digit_ok;
    logic            match;
    logic [15:0]     entry_buf;
    logic [1:0]      fail_next;

    logic            shift_en;
    logic            clear_buf;
    logic            store_pw;
    logic            fail_inc;
    logic            fail_clr;
    logic            unlock_d;
    logic            buzz_d;

    assign state     = cur_state;
    assign entry_buf = {out_4, out_3, out_2, out_1};
    assign fail_next = fail_cnt + 2'd1;

    // Only the highest-priority key of a cycle is seen: key2 > key1 > key0 > key3.
    assign k2 = key2;
    assign k1 = key1 & ~key2;
    assign k0 = key0 & ~key1 & ~key2;
    assign k3 = key3 & ~key0 & ~key1 & ~key2;

    assign digit_ok = k0 && (digit_in <= 4'd9) && (count < 3'd4);

`ifdef LOCK_MASTER_CODE_EN
    assign match = (count == 3'd4) && ((entry_buf == password) || (entry_buf == 16'h9999));
`else
    assign match = (count == 3'd4) && (entry_buf == password);
`endif

    // Select the final timer value for whichever timed state is active.
    always_comb begin
        timer_last  = '0;
        timed_state = 1'b0;
        case (cur_state)
            S_OPEN: begin
                timer_last  = OPEN_LAST;
                timed_state = 1'b1;
            end
            S_FAIL: begin
                timer_last  = FAIL_LAST;
                timed_state = 1'b1;
            end
            S_LOCKOUT: begin
                timer_last  = LOCKOUT_LAST;
                timed_state = 1'b1;
            end
            default: begin
                timer_last  = '0;
                timed_state = 1'b0;
            end
        endcase
    end

    assign timer_done = timed_state && (timer == timer_last);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic plus the datapath strobes that go with each transition.
    always_comb begin
        nxt_state = cur_state;
        shift_en  = 1'b0;
        clear_buf = 1'b0;
        store_pw  = 1'b0;
        fail_inc  = 1'b0;
        fail_clr  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (k2) begin
                    clear_buf = 1'b1;
                end else if (digit_ok) begin
                    shift_en  = 1'b1;
                    nxt_state = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (k2) begin
                    clear_buf = 1'b1;
                    nxt_state = S_IDLE;
                end else if (k1) begin
                    nxt_state = S_CHECK;
                end else if (digit_ok) begin
                    shift_en = 1'b1;
                end
            end
            S_CHECK: begin
                if (match) begin
                    fail_clr  = 1'b1;
                    nxt_state = S_OPEN;
                end else begin
                    fail_inc  = 1'b1;
                    nxt_state = (fail_next == MAX_FAIL_L) ? S_LOCKOUT : S_FAIL;
                end
            end
            S_OPEN: begin
                if (timer_done || k2) begin
                    clear_buf = 1'b1;
                    nxt_state = S_IDLE;
                end else if (k3 && switch4) begin
                    clear_buf = 1'b1;
                    nxt_state = S_SETPW;
                end
            end
            S_FAIL: begin
                if (timer_done) begin
                    clear_buf = 1'b1;
                    nxt_state = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer_done) begin
                    clear_buf = 1'b1;
                    fail_clr  = 1'b1;
                    nxt_state = S_IDLE;
                end
            end
            S_SETPW: begin
                if (k2) begin
                    clear_buf = 1'b1;
                    nxt_state = S_IDLE;
                end else if (k1 && (count == 3'd4)) begin
                    store_pw  = 1'b1;
                    clear_buf = 1'b1;
                    nxt_state = S_IDLE;
                end else if (digit_ok) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                clear_buf = 1'b1;
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track the state register.
    always_comb begin
        unlock_d = (nxt_state == S_OPEN);
        buzz_d   = (nxt_state == S_FAIL) || (nxt_state == S_LOCKOUT);
    end

    // Registered servo and buzzer outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unlock <= 1'b0;
            buzz   <= 1'b0;
        end else begin
            unlock <= unlock_d;
            buzz   <= buzz_d;
        end
    end

    // Entry buffer, digit count, stored password and failure counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_1    <= 4'd0;
            out_2    <= 4'd0;
            out_3    <= 4'd0;
            out_4    <= 4'd0;
            count    <= 3'd0;
            password <= RESET_CODE;
            fail_cnt <= 2'd0;
        end else begin
            if (store_pw) begin
                password <= entry_buf;
            end
            if (clear_buf) begin
                out_1 <= 4'd0;
                out_2 <= 4'd0;
                out_3 <= 4'd0;
                out_4 <= 4'd0;
                count <= 3'd0;
            end else if (shift_en) begin
                out_4 <= out_3;
                out_3 <= out_2;
                out_2 <= out_1;
                out_1 <= digit_in;
                count <= count + 3'd1;
            end
            if (fail_clr) begin
                fail_cnt <= 2'd0;
            end else if (fail_inc) begin
                fail_cnt <= fail_next;
            end
        end
    end

    // Dwell timer: restarts on every state change, counts while a timed state persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (timed_state && (nxt_state == cur_state)) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// tb/tb_digital_lock_ctrl.sv - directed self-checking bench for digital_lock_ctrl
module tb_digital_lock_ctrl;

    localparam int OC = 5;
    localparam int FC = 3;
    localparam int LC = 7;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;
    localparam logic [2:0] S_SETPW   = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       key0 = 1'b0;
    logic       key1 = 1'b0;
    logic       key2 = 1'b0;
    logic       key3 = 1'b0;
    logic       switch4 = 1'b0;
    logic [3:0] out_1;
    logic [3:0] out_2;
    logic [3:0] out_3;
    logic [3:0] out_4;
    logic       unlock;
    logic       buzz;
    logic [2:0] state;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    digital_lock_ctrl #(
        .RESET_CODE    (16'h1234),
        .OPEN_CYCLES   (OC),
        .FAIL_CYCLES   (FC),
        .LOCKOUT_CYCLES(LC),
        .MAX_FAIL      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .digit_in(digit_in),
        .key0    (key0),
        .key1    (key1),
        .key2    (key2),
        .key3    (key3),
        .switch4 (switch4),
        .out_1   (out_1),
        .out_2   (out_2),
        .out_3   (out_3),
        .out_4   (out_4),
        .unlock  (unlock),
        .buzz    (buzz),
        .state   (state),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bufv();
        return {out_4, out_3, out_2, out_1};
    endfunction

    // Pulse one key for one clock; called and returns at a falling edge.
    task automatic key(input int k, input logic [3:0] d);
        digit_in = d;
        case (k)
            0: key0 = 1'b1;
            1: key1 = 1'b1;
            2: key2 = 1'b1;
            default: key3 = 1'b1;
        endcase
        @(negedge clk);
        key0 = 1'b0;
        key1 = 1'b0;
        key2 = 1'b0;
        key3 = 1'b0;
    endtask

    task automatic enter4(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) key(0, code[i*4 +: 4]);
    endtask

    task automatic submit(input string tag);
        key(1, 4'd0);
        chk({tag, "_check"}, {13'd0, state}, {13'd0, S_CHECK});
    endtask

    // Expect a timed state for exactly n cycles, then IDLE with cleared buffer.
    task automatic timed(input string tag, input logic [2:0] st, input int n,
                         input logic u, input logic b, input bit inject);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_state"}, {13'd0, state}, {13'd0, st});
            chk({tag, "_unlock"}, {15'd0, unlock}, {15'd0, u});
            chk({tag, "_buzz"}, {15'd0, buzz}, {15'd0, b});
            if (inject && i == 1) begin
                digit_in = 4'd7;
                key0 = 1'b1;
                key1 = 1'b1;
                key3 = 1'b1;
            end
            if (inject && i == 2) begin
                key0 = 1'b0;
                key1 = 1'b0;
                key3 = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_exit_state"}, {13'd0, state}, {13'd0, S_IDLE});
        chk({tag, "_exit_unlock"}, {15'd0, unlock}, 16'd0);
        chk({tag, "_exit_buzz"}, {15'd0, buzz}, 16'd0);
        chk({tag, "_exit_buf"}, bufv(), 16'h0000);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_state", {13'd0, state}, 16'd0);
        chk("rst_buf", bufv(), 16'h0000);
        chk("rst_unlock", {15'd0, unlock}, 16'd0);
        chk("rst_buzz", {15'd0, buzz}, 16'd0);
        chk("rst_fail", {14'd0, fail_cnt}, 16'd0);
        rst = 1'b0;

        // Submit and change-password keys ignored in IDLE
        key(1, 4'd0);
        chk("idle_key1", {13'd0, state}, {13'd0, S_IDLE});
        key(3, 4'd0);
        chk("idle_key3", {13'd0, state}, {13'd0, S_IDLE});

        // Correct code opens for exactly OC cycles
        key(0, 4'd1);
        chk("first_digit", {13'd0, state}, {13'd0, S_ENTRY});
        key(0, 4'd2);
        key(0, 4'd3);
        key(0, 4'd4);
        chk("buf_1234", bufv(), 16'h1234);
        submit("open1");
        timed("open1", S_OPEN, OC, 1'b1, 1'b0, 1'b0);

        // Invalid digit, overflow digit, key0+key2 in one cycle
        key(0, 4'd1);
        key(0, 4'd2);
        key(0, 4'hA);
        chk("invalid_digit", bufv(), 16'h0012);
        key(0, 4'd3);
        key(0, 4'd4);
        key(0, 4'd5);
        chk("fifth_digit", bufv(), 16'h1234);
        digit_in = 4'd6;
        key0 = 1'b1;
        key2 = 1'b1;
        @(negedge clk);
        key0 = 1'b0;
        key2 = 1'b0;
        chk("clear_state", {13'd0, state}, {13'd0, S_IDLE});
        chk("clear_buf", bufv(), 16'h0000);

        // Two failures then lockout with keys ignored
        enter4(16'h1235);
        submit("fail1");
        timed("fail1", S_FAIL, FC, 1'b0, 1'b1, 1'b0);
        chk("fail1_cnt", {14'd0, fail_cnt}, 16'd1);
        enter4(16'h1235);
        submit("fail2");
        timed("fail2", S_FAIL, FC, 1'b0, 1'b1, 1'b0);
        chk("fail2_cnt", {14'd0, fail_cnt}, 16'd2);
        enter4(16'h1235);
        submit("lock1");
        timed("lock1", S_LOCKOUT, LC, 1'b0, 1'b1, 1'b1);
        chk("lock1_cnt", {14'd0, fail_cnt}, 16'd0);

        // Password change through OPEN -> SETPW
        enter4(16'h1234);
        submit("open2");
        @(negedge clk);
        chk("open2_state", {13'd0, state}, {13'd0, S_OPEN});
        key(3, 4'd0);
        chk("key3_no_admin", {13'd0, state}, {13'd0, S_OPEN});
        switch4 = 1'b1;
        key(3, 4'd0);
        switch4 = 1'b0;
        chk("setpw_state", {13'd0, state}, {13'd0, S_SETPW});
        chk("setpw_unlock", {15'd0, unlock}, 16'd0);
        chk("setpw_buf", bufv(), 16'h0000);
        key(0, 4'd5);
        key(0, 4'd6);
        key(0, 4'd7);
        key(1, 4'd0);
        chk("setpw_short", {13'd0, state}, {13'd0, S_SETPW});
        key(0, 4'd8);
        key(1, 4'd0);
        chk("setpw_store", {13'd0, state}, {13'd0, S_IDLE});
        chk("setpw_store_buf", bufv(), 16'h0000);
        enter4(16'h1234);
        submit("oldpw");
        timed("oldpw", S_FAIL, FC, 1'b0, 1'b1, 1'b0);
        chk("oldpw_cnt", {14'd0, fail_cnt}, 16'd1);
        enter4(16'h5678);
        submit("newpw");
        @(negedge clk);
        chk("newpw_state", {13'd0, state}, {13'd0, S_OPEN});
        chk("newpw_unlock", {15'd0, unlock}, 16'd1);
        chk("newpw_cnt", {14'd0, fail_cnt}, 16'd0);
        key(2, 4'd0);
        chk("abort_state", {13'd0, state}, {13'd0, S_IDLE});
        chk("abort_unlock", {15'd0, unlock}, 16'd0);

        // Master code with two failures pending
        enter4(16'h1111);
        submit("m1");
        timed("m1", S_FAIL, FC, 1'b0, 1'b1, 1'b0);
        enter4(16'h1111);
        submit("m2");
        timed("m2", S_FAIL, FC, 1'b0, 1'b1, 1'b0);
        chk("m2_cnt", {14'd0, fail_cnt}, 16'd2);
        enter4(16'h9999);
        submit("master");
`ifdef LOCK_MASTER_CODE_EN
        @(negedge clk);
        chk("master_state", {13'd0, state}, {13'd0, S_OPEN});
        chk("master_cnt", {14'd0, fail_cnt}, 16'd0);
        key(2, 4'd0);
        chk("master_exit", {13'd0, state}, {13'd0, S_IDLE});
`else
        timed("master", S_LOCKOUT, LC, 1'b0, 1'b1, 1'b0);
        chk("master_cnt", {14'd0, fail_cnt}, 16'd0);
`endif

        // Asynchronous reset mid-OPEN restores the reset password
        enter4(16'h5678);
        submit("open3");
        @(negedge clk);
        chk("open3_unlock", {15'd0, unlock}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_unlock", {15'd0, unlock}, 16'd0);
        chk("async_state", {13'd0, state}, {13'd0, S_IDLE});
        chk("async_buf", bufv(), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        enter4(16'h1234);
        submit("open4");
        timed("open4", S_OPEN, OC, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
